// File: rtl/uart_pkg.sv
// Shared types and helpers for the framed UART transmitter.
// Holds the FSM encoding, parity mode codes and the data_bits decode.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // 0..4 select 5..9 data bits; the unused codes fall back to the widest frame
  function automatic logic [3:0] decode_nbits(input logic [2:0] data_bits);
    return (data_bits <= 3'd4) ? (4'(data_bits) + 4'd5) : 4'd9;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // storage is flushed by the pointers, so it needs no reset
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_framed.sv
// UART transmitter: FIFO-fed, runtime baud divisor, 5..9 data bits,
// optional even/odd parity, 1 or 2 stop bits. Line idles high.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [2:0]                    data_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    bit_cnt;
  logic [3:0]          bit_idx;
  logic [DATA_W-1:0]   shreg;
  logic                par;
  logic [DIV_W-1:0]    div_q;
  logic [3:0]          nbits_q;
  logic [1:0]          pmode_q;
  logic                stop2_q;

  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_rdata;
  logic                bit_end;
  logic                has_par;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (in_valid),
    .wdata   (in_data),
    .pop     (state == ST_LOAD),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state != ST_IDLE) || !fifo_empty;
  assign bit_end  = (bit_cnt == '0);
  assign has_par  = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!fifo_empty) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_START;
      ST_START:  if (bit_end) state_nxt = ST_DATA;
      ST_DATA:   if (bit_end && bit_idx == nbits_q - 4'd1)
                   state_nxt = has_par ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
      ST_STOP:   if (bit_end && (!stop2_q || bit_idx == 4'd1))
                   state_nxt = fifo_empty ? ST_IDLE : ST_LOAD;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shreg[0];
      ST_PARITY: tx = par;
      default:   tx = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      div_q   <= '0;
      nbits_q <= 4'd5;
      pmode_q <= PAR_NONE;
      stop2_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_LOAD) begin
        shreg   <= fifo_rdata;
        div_q   <= baud_div;
        nbits_q <= decode_nbits(data_bits);
        pmode_q <= parity_mode;
        stop2_q <= stop2;
        bit_cnt <= baud_div;
        bit_idx <= '0;
        // odd parity is even parity seeded with a one
        par     <= (parity_mode == PAR_ODD);
      end else if (state != ST_IDLE) begin
        if (bit_end) begin
          bit_cnt <= div_q;
          // index advances only while repeating a state (data bits, second stop)
          bit_idx <= (state_nxt == state) ? bit_idx + 4'd1 : 4'd0;
          if (state == ST_DATA) begin
            shreg <= shreg >> 1;
            par   <= par ^ shreg[0];
          end
        end else begin
          bit_cnt <= bit_cnt - DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: a bit-list reference model feeds a scoreboard
// queue; an independent line monitor decodes tx clock by clock against it.
module tb_uart_tx_framed;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [8:0]  in_data = '0;
  logic        in_ready;
  logic [15:0] baud_div = '0;
  logic [2:0]  data_bits = '0;
  logic [1:0]  parity_mode = '0;
  logic        stop2 = 1'b0;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_level;

  always #5 clock = ~clock;

  uart_tx_framed #(.DATA_W(9), .FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .baud_div    (baud_div),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .tx          (tx),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  typedef struct {
    logic [12:0] bits;
    int          nbits;
    int          per;
  } frame_t;

  frame_t exp_q[$];
  int     gap_q[$];
  int     n_chk = 0;
  int     n_pass = 0;
  bit     mon_en = 1'b1;
  bit     in_frame = 1'b0;
  int     max_level = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Frame as the line should carry it: start, LSB-first data, parity, stops.
  function automatic frame_t model(input logic [8:0] w, input logic [2:0] db,
                                   input logic [1:0] pm, input logic s2,
                                   input logic [15:0] div);
    frame_t f;
    int     nb;
    logic   p;
    nb = (int'(db) <= 4) ? int'(db) + 5 : 9;
    f.bits = '0;
    f.per  = int'(div) + 1;
    f.bits[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      f.bits[1 + i] = w[i];
      p = p ^ w[i];
    end
    f.nbits = 1 + nb;
    if (pm == 2'd1 || pm == 2'd2) begin
      f.bits[f.nbits] = (pm == 2'd2) ? ~p : p;
      f.nbits++;
    end
    f.bits[f.nbits] = 1'b1;
    f.nbits++;
    if (s2) begin
      f.bits[f.nbits] = 1'b1;
      f.nbits++;
    end
    return f;
  endfunction

  task automatic push(input logic [8:0] w, output bit acc);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = w;
    acc      = in_ready;
    if (acc) exp_q.push_back(model(w, data_bits, parity_mode, stop2, baud_div));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [8:0] w);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 2000) begin
      push(w, acc);
      t++;
    end
    if (!acc) check(1'b0, "push_timeout", t, 2000);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || in_frame || busy) && t < 20000) begin
      @(negedge clock);
      t++;
    end
    check(t < 20000, "drain_timeout", t, 20000);
    repeat (2) @(negedge clock);
  endtask

  always @(negedge clock) if (int'(fifo_level) > max_level) max_level = int'(fifo_level);

  // line monitor
  initial begin : monitor
    int     idle;
    frame_t f;
    bit     ok;
    int     t;
    idle = 0;
    forever begin
      @(negedge clock);
      if (!reset_n || !mon_en) idle = 0;
      else if (tx === 1'b1) idle++;
      else if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_start", int'(tx), 1);
        t = 0;
        while (tx !== 1'b1 && t < 200) begin @(negedge clock); t++; end
        idle = 0;
      end else begin
        in_frame = 1'b1;
        gap_q.push_back(idle);
        f = exp_q.pop_front();
        for (int b = 0; b < f.nbits; b++) begin
          ok = 1'b1;
          for (int c = 0; c < f.per; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clock);
            if (tx !== f.bits[b]) ok = 1'b0;
          end
          check(ok, $sformatf("line_bit%0d", b), int'(tx), int'(f.bits[b]));
        end
        idle = 0;
        in_frame = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit acc;
    int n_acc;
    bit ok;

    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check(tx === 1'b1, "rst_tx", int'(tx), 1);
    check(busy === 1'b0, "rst_busy", int'(busy), 0);
    check(in_ready === 1'b1, "rst_in_ready", int'(in_ready), 1);
    check(fifo_level === 3'd0, "rst_level", int'(fifo_level), 0);
    reset_n = 1'b1;

    // 8N1 at 4 clk/bit, plus push-to-start latency
    baud_div = 16'd3; data_bits = 3'd3; parity_mode = 2'd0; stop2 = 1'b0;
    push(9'h0A5, acc);
    check(acc, "t1_accept", int'(acc), 1);
    @(negedge clock);
    check(fifo_level === 3'd1, "lat_level_k", int'(fifo_level), 1);
    check(tx === 1'b1, "lat_tx_k", int'(tx), 1);
    @(negedge clock);
    check(tx === 1'b1, "lat_tx_k1", int'(tx), 1);
    check(busy === 1'b1, "lat_busy_k1", int'(busy), 1);
    @(negedge clock);
    check(tx === 1'b0, "lat_tx_k2", int'(tx), 0);
    check(fifo_level === 3'd0, "lat_level_k2", int'(fifo_level), 0);
    drain();
    check(busy === 1'b0, "t1_busy_end", int'(busy), 0);

    // 7E2 at 1 clk/bit
    baud_div = 16'd0; data_bits = 3'd2; parity_mode = 2'd1; stop2 = 1'b1;
    push_wait(9'h035);
    drain();

    // 9O1, 5N1, unused data_bits code, parity code 3
    baud_div = 16'd1; data_bits = 3'd4; parity_mode = 2'd2; stop2 = 1'b0;
    push_wait(9'h1FF);
    drain();
    data_bits = 3'd0; parity_mode = 2'd0;
    push_wait(9'h03F);
    drain();
    data_bits = 3'd6; parity_mode = 2'd3; stop2 = 1'b1;
    push_wait(9'h155);
    drain();

    // FIFO fill while the line is busy
    baud_div = 16'd7; data_bits = 3'd3; parity_mode = 2'd0; stop2 = 1'b0;
    push_wait(9'h011);
    repeat (3) @(negedge clock);
    gap_q.delete();
    max_level = 0;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      push(9'(9'h040 + i), acc);
      n_acc += int'(acc);
      if (i == 3) begin
        check(fifo_level === 3'd4, "full_level", int'(fifo_level), 4);
        check(in_ready === 1'b0, "full_in_ready", int'(in_ready), 0);
      end
    end
    check(n_acc == 4, "full_accepted", n_acc, 4);
    check(fifo_level === 3'd4, "full_no_overwrite", int'(fifo_level), 4);
    drain();
    check(max_level <= 4, "max_level", max_level, 4);
    check(gap_q.size() == 4, "b2b_frames", gap_q.size(), 4);
    foreach (gap_q[i]) check(gap_q[i] == 1, $sformatf("b2b_gap%0d", i), gap_q[i], 1);

    // reset mid-frame flushes everything
    mon_en = 1'b0;
    baud_div = 16'd3;
    push_wait(9'h05A);
    push_wait(9'h033);
    repeat (12) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check(tx === 1'b1, "midrst_tx", int'(tx), 1);
    check(busy === 1'b0, "midrst_busy", int'(busy), 0);
    check(fifo_level === 3'd0, "midrst_level", int'(fifo_level), 0);
    check(in_ready === 1'b1, "midrst_in_ready", int'(in_ready), 1);
    reset_n = 1'b1;
    exp_q.delete();
    ok = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    check(ok, "postrst_idle", int'(tx), 1);
    mon_en = 1'b1;
    push_wait(9'h0C3);
    drain();

    // divisor change mid-frame takes effect on the next frame only
    baud_div = 16'd3;
    push_wait(9'h096);
    repeat (6) @(negedge clock);
    baud_div = 16'd7;
    push_wait(9'h069);
    drain();

    // randomized groups, config held constant within each group
    for (int g = 0; g < 8; g++) begin
      baud_div    = 16'($urandom_range(0, 4));
      data_bits   = 3'($urandom_range(0, 7));
      parity_mode = 2'($urandom_range(0, 3));
      stop2       = 1'($urandom_range(0, 1));
      for (int n = 0; n < int'($urandom_range(1, 6)); n++) begin
        push_wait(9'($urandom_range(0, 511)));
        repeat ($urandom_range(0, 3)) @(negedge clock);
      end
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
